writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Writeback stage directly upstream of the register file. It owns the file's single write port (wen/rd/dataD).
//   Merges results from the execute unit (EXU) and the load/store unit (LSU), and aligns and sign/zero-extends load data.
//   Registers the selected write for one cycle.
//   Keeps a load scoreboard. Issue stalls on RAW/WAW hazards against outstanding loads.
// PARAMETERS
//   ADDR_WIDTH   5    register index width; the scoreboard has 1<<ADDR_WIDTH entries
//   DATA_WIDTH   64   register data width; must be 64 (LD/LWU support)
//   CNT_WIDTH    4    width of the outstanding-load counter
// PORTS
//   clk           in   1           clock; all state changes on posedge
//   rst           in   1           asynchronous, active-high reset
//   exu_valid     in   1           EXU result offered
//   exu_ready     out  1           EXU result accepted this cycle when exu_valid & exu_ready
//   exu_wen       in   1           EXU result writes rd
//   exu_rd        in   ADDR_WIDTH  EXU destination register
//   exu_data      in   DATA_WIDTH  EXU result
//   lsu_valid     in   1           load data offered
//   lsu_ready     out  1           load data accepted; tied to 1
//   lsu_rd        in   ADDR_WIDTH  load destination register
//   lsu_funct3    in   3           load type (RV64 encoding)
//   lsu_offset    in   3           byte offset of the access inside the 64-bit word
//   lsu_rdata     in   DATA_WIDTH  raw aligned-doubleword read data
//   issue_valid   in   1           decode presents an instruction
//   issue_is_load in   1           that instruction is a load
//   issue_rs1     in   ADDR_WIDTH  source register 1
//   issue_rs2     in   ADDR_WIDTH  source register 2
//   issue_rd      in   ADDR_WIDTH  destination register
//   issue_stall   out  1           decode must hold the instruction
//   pending_loads out  CNT_WIDTH   number of outstanding loads
//   rf_wen        out  1           to register file wen
//   rf_rd         out  ADDR_WIDTH  to register file rd
//   rf_data       out  DATA_WIDTH  to register file dataD
// BEHAVIOUR
//   Reset: rf_wen=0, rf_rd=0, rf_data=0, pending_loads=0, all busy bits 0. In-flight results are dropped.
//   Arbitration: fixed priority, LSU over EXU.
//     lsu_ready=1.
//     exu_ready=!lsu_valid (combinational). EXU holds its offer until accepted.
//   Latency: an accept at edge N drives rf_wen/rf_rd/rf_data during cycle N+1, for exactly one cycle.
//     rf_wen=0 in any cycle that follows no qualifying accept.
//   Write qualification: LSU accepts always write; EXU accepts write only if exu_wen=1.
//     Any write with rd==0 still completes the handshake but leaves rf_wen=0.
//   Load formatting: s = lsu_rdata >> (8*lsu_offset), then by funct3:
//     000 LB  sext(s[7:0])     100 LBU  zext(s[7:0])
//     001 LH  sext(s[15:0])    101 LHU  zext(s[15:0])
//     010 LW  sext(s[31:0])    110 LWU  zext(s[31:0])
//     011 LD  s                111      s (treated as LD)
//   Misaligned offsets are not checked; bytes shifted past bit 63 read as 0.
//   Scoreboard:
//     issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), using registered busy bits only.
//     No same-cycle bypass: a load writing back at edge N unblocks its dependant from cycle N+1.
//     busy[0] is constantly 0.
//     Set busy[issue_rd] when issue_valid & issue_is_load & !issue_stall & issue_rd!=0.
//     Clear busy[lsu_rd] on an LSU accept.
//     Set and clear of the same index in one cycle: set wins.
//   pending_loads:
//     +1 on a qualifying load issue (including rd==0); -1 on an LSU accept; both at once leaves it unchanged.
//     Saturates at all-ones and 0; it never wraps.
//     When saturated, issue_stall also asserts for issue_is_load.
// TESTING
//   EXU valid, rd=5, data=0x1234, wen=1 at edge 1 -> cycle 2: rf_wen=1, rf_rd=5, rf_data=0x1234; cycle 3: rf_wen=0.
//   LSU and EXU valid together (LSU rd=3, EXU rd=4) -> exu_ready=0; x3 written first, x4 written the following cycle.
//   LSU rdata=0x00000000_80FF0000, funct3=000, offset=2 -> rf_data=0xFFFFFFFF_FFFFFFFF.
//     Same stimulus with funct3=100 -> rf_data=0xFF.
//   Issue load rd=7, then add rs1=7 -> issue_stall=1 until the cycle after LSU accepts rd=7; pending_loads goes 1 -> 0.
//   rd=0 cases: EXU rd=0 with wen=1 -> rf_wen stays 0. Load issue with rd=0 -> no busy bit set, pending_loads +1.
//   Async reset: assert rst mid-stream with busy[9]=1 and rf_wen=1 -> outputs and busy clear immediately, without waiting for clk.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges EXU and LSU results into the register file write port
// and keeps a load scoreboard that stalls issue on hazards against pending loads.
module writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [2:0]            lsu_funct3,
  input  logic [2:0]            lsu_offset,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic                  issue_valid,
  input  logic                  issue_is_load,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_stall,
  output logic [CNT_WIDTH-1:0]  pending_loads,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  cnt_full;
  logic                  cnt_empty;
  logic                  lsu_acc;
  logic                  exu_acc;
  logic                  hazard;
  logic                  load_issue;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  wen_d;
  logic [ADDR_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] data_d;

  assign lsu_ready  = 1'b1;
  assign exu_ready  = !lsu_valid;
  assign lsu_acc    = lsu_valid;
  assign exu_acc    = exu_valid & exu_ready;

  assign cnt_full   = &pending_loads;
  assign cnt_empty  = pending_loads == '0;

  // Hazard check uses registered busy bits only; no writeback bypass.
  assign hazard      = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd];
  assign issue_stall = issue_valid &
                       (hazard | (issue_is_load & cnt_full));
  assign load_issue  = issue_valid & issue_is_load & !issue_stall;

  assign shifted = lsu_rdata >> {lsu_offset, 3'b000};

  // Extract and extend the loaded field according to funct3.
  always_comb begin
    ld_data = shifted;
    unique case (lsu_funct3)
      3'b000: ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001: ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010: ld_data = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b100: ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101: ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      3'b110: ld_data = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      3'b011,
      3'b111: ld_data = shifted;
    endcase
  end

  // Pick the write for next cycle: LSU first, writes to x0 suppressed.
  always_comb begin
    wen_d  = 1'b0;
    rd_d   = rf_rd;
    data_d = rf_data;
    unique case (1'b1)
      lsu_acc: begin
        wen_d  = lsu_rd != '0;
        rd_d   = lsu_rd;
        data_d = ld_data;
      end
      exu_acc: begin
        wen_d  = exu_wen & (exu_rd != '0);
        rd_d   = exu_rd;
        data_d = exu_data;
      end
      default: ;
    endcase
  end

  // Busy bits: clear on load return, then set on issue so set wins.
  always_comb begin
    busy_d = busy;
    if (lsu_acc)
      busy_d[lsu_rd] = 1'b0;
    if (load_issue)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Outstanding-load count, saturating at both ends.
  always_comb begin
    cnt_d = pending_loads;
    if (load_issue && !lsu_acc && !cnt_full)
      cnt_d = pending_loads + 1'b1;
    else if (lsu_acc && !load_issue && !cnt_empty)
      cnt_d = pending_loads - 1'b1;
  end

  // Register the selected write and the scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen        <= 1'b0;
      rf_rd         <= '0;
      rf_data       <= '0;
      busy          <= '0;
      pending_loads <= '0;
    end else begin
      rf_wen        <= wen_d;
      rf_rd         <= rd_d;
      rf_data       <= data_d;
      busy          <= busy_d;
      pending_loads <= cnt_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic
// checked against a behavioural scoreboard model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid, exu_wen, lsu_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [63:0] exu_data, lsu_rdata;
  logic [2:0]  lsu_funct3, lsu_offset;
  logic        issue_valid, issue_is_load, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic [3:0]  pending_loads;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;

  int checks = 0;
  int errors = 0;

  bit          busy_m [32];
  int          pend_m;
  bit          ew;
  int          er;
  logic [63:0] ed;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready),
    .exu_wen(exu_wen), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
    .lsu_offset(lsu_offset), .lsu_rdata(lsu_rdata),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .pending_loads(pending_loads),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fmt(logic [63:0] raw,
                                      logic [2:0] f3,
                                      logic [2:0] off);
    logic [63:0] s, mask, v;
    int nb;
    s  = raw >> (8 * int'(off));
    nb = (f3[1:0] == 2'd3) ? 8 : (1 << f3[1:0]);
    if (nb == 8) return s;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = s & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit stall_model();
    if (!issue_valid) return 1'b0;
    return busy_m[issue_rs1] || busy_m[issue_rs2] || busy_m[issue_rd] ||
           (issue_is_load && pend_m == 15);
  endfunction

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    pend_m = 0;
    ew = 1'b0;
  endtask

  task automatic idle();
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0;
    lsu_offset = 0; lsu_rdata = 0;
    issue_valid = 0; issue_is_load = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    bit st, iok;
    @(negedge clk);
    st = stall_model();
    chk("exu_ready", exu_ready, !lsu_valid);
    chk("lsu_ready", lsu_ready, 1);
    chk("issue_stall", issue_stall, st);
    iok = issue_valid && issue_is_load && !st;
    if (lsu_valid) begin
      ew = lsu_rd != 0; er = lsu_rd;
      ed = fmt(lsu_rdata, lsu_funct3, lsu_offset);
    end else if (exu_valid) begin
      ew = exu_wen && exu_rd != 0; er = exu_rd; ed = exu_data;
    end else begin
      ew = 1'b0;
    end
    if (lsu_valid) busy_m[lsu_rd] = 1'b0;
    if (iok && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    pend_m = pend_m + int'(iok) - int'(lsu_valid);
    if (pend_m < 0) pend_m = 0;
    if (pend_m > 15) pend_m = 15;
    @(posedge clk);
    #1;
    chk("rf_wen", rf_wen, ew);
    if (ew) begin
      chk("rf_rd", rf_rd, er);
      chk("rf_data", rf_data, ed);
    end
    chk("pending_loads", pending_loads, pend_m);
  endtask

  initial begin
    bit held;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_wen", rf_wen, 0);
    chk("reset rf_rd", rf_rd, 0);
    chk("reset rf_data", rf_data, 0);
    chk("reset pending", pending_loads, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // EXU write to x5, then idle
    exu_valid = 1; exu_wen = 1; exu_rd = 5; exu_data = 64'h1234;
    step();
    chk("exu x5 wen", rf_wen, 1);
    chk("exu x5 data", rf_data, 64'h1234);
    idle();
    step();
    chk("exu x5 one cycle", rf_wen, 0);

    // LSU beats EXU, EXU follows
    lsu_valid = 1; lsu_rd = 3; lsu_funct3 = 3'b011; lsu_rdata = 64'hAB;
    exu_valid = 1; exu_wen = 1; exu_rd = 4; exu_data = 64'hCD;
    step();
    chk("arb lsu first", rf_rd, 3);
    lsu_valid = 0;
    step();
    chk("arb exu next", rf_rd, 4);
    chk("arb exu data", rf_data, 64'hCD);
    idle();

    // Load formatting at offset 2
    lsu_valid = 1; lsu_rd = 1; lsu_offset = 2;
    lsu_rdata = 64'h00000000_80FF0000; lsu_funct3 = 3'b000;
    step();
    chk("lb sext", rf_data, 64'hFFFF_FFFF_FFFF_FFFF);
    lsu_funct3 = 3'b100;
    step();
    chk("lbu zext", rf_data, 64'hFF);
    idle();

    // RAW hazard on x7
    issue_valid = 1; issue_is_load = 1; issue_rd = 7;
    step();
    chk("x7 pending", pending_loads, 1);
    issue_is_load = 0; issue_rs1 = 7; issue_rd = 8;
    step();
    step();
    lsu_valid = 1; lsu_rd = 7; lsu_funct3 = 3'b011;
    step();
    lsu_valid = 0;
    #1;
    chk("x7 unblocked", issue_stall, 0);
    chk("x7 drained", pending_loads, 0);
    step();
    idle();

    // Writes and load issues to x0
    exu_valid = 1; exu_wen = 1; exu_rd = 0; exu_data = 64'h99;
    step();
    chk("x0 exu", rf_wen, 0);
    idle();
    issue_valid = 1; issue_is_load = 1; issue_rd = 0;
    for (int i = 0; i < 15; i++) step();
    chk("sat count", pending_loads, 15);
    #1;
    chk("sat stall", issue_stall, 1);
    step();
    issue_is_load = 0;
    step();
    idle();
    lsu_valid = 1; lsu_rd = 0;
    for (int i = 0; i < 16; i++) step();
    chk("drain floor", pending_loads, 0);
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      held = exu_valid && lsu_valid;
      lsu_valid = ($urandom_range(0, 3) == 0) ||
                  (pend_m > 0 && $urandom_range(0, 1) == 1);
      lsu_rd = 5'($urandom_range(0, 7));
      lsu_funct3 = 3'($urandom);
      lsu_offset = 3'($urandom);
      lsu_rdata = {$urandom, $urandom};
      if (!held) begin
        exu_valid = 1'($urandom);
        exu_wen = ($urandom_range(0, 3) != 0);
        exu_rd = 5'($urandom_range(0, 7));
        exu_data = {$urandom, $urandom};
      end
      issue_valid = 1'($urandom);
      issue_is_load = 1'($urandom);
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      issue_rd = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    model_reset();
    step();
    step();

    // Asynchronous reset while x9 busy and a write is in flight
    idle();
    model_reset();
    lsu_valid = 1;
    for (int i = 0; i < 16; i++) step();
    idle();
    model_reset();
    issue_valid = 1; issue_is_load = 1; issue_rd = 9;
    step();
    idle();
    exu_valid = 1; exu_wen = 1; exu_rd = 5; exu_data = 64'h77;
    step();
    chk("pre-rst wen", rf_wen, 1);
    idle();
    issue_valid = 1; issue_rs1 = 9;
    #1;
    chk("pre-rst stall", issue_stall, 1);
    rst = 1;
    #1;
    chk("async rf_wen", rf_wen, 0);
    chk("async rf_rd", rf_rd, 0);
    chk("async rf_data", rf_data, 0);
    chk("async pending", pending_loads, 0);
    chk("async busy", issue_stall, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle();
    @(posedge clk);
    #1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
